// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// states, opcode/func fields, ALU codes, mux selects and instruction classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef logic [3:0] alu_t;

  localparam alu_t ALU_ADD = 4'd0;
  localparam alu_t ALU_SUB = 4'd1;
  localparam alu_t ALU_AND = 4'd2;
  localparam alu_t ALU_OR  = 4'd3;
  localparam alu_t ALU_SLT = 4'd4;
  localparam alu_t ALU_SLL = 4'd5;
  localparam alu_t ALU_SRL = 4'd6;
  localparam alu_t ALU_LUI = 4'd7;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT   = 2'd0;
  localparam logic [1:0] RD_RD   = 2'd1;
  localparam logic [1:0] RD_LINK = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] AS_RT   = 2'd0;
  localparam logic [1:0] AS_SEXT = 2'd1;
  localparam logic [1:0] AS_ZEXT = 2'd2;

  typedef enum logic [3:0] {
    C_NONE = 4'd0,
    C_RALU = 4'd1,
    C_JR   = 4'd2,
    C_IALU = 4'd3,
    C_LW   = 4'd4,
    C_SW   = 4'd5,
    C_BEQ  = 4'd6,
    C_BNE  = 4'd7,
    C_J    = 4'd8,
    C_JAL  = 4'd9,
    C_ILL  = 4'd10
  } cls_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational op/func decoder: instruction class, ALU code,
// ALU B-operand select and an undefined-instruction flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output cls_t       cls_o,
  output alu_t       alu_o,
  output logic [1:0] alu_src_o,
  output logic       illegal_o
);

  // Map the opcode (and func for R-type) onto a class and ALU setup
  always_comb begin
    cls_o     = C_ILL;
    alu_o     = ALU_ADD;
    alu_src_o = AS_RT;
    unique case (op_i)
      OP_RTYPE: begin
        unique case (func_i)
          F_ADDU: begin cls_o = C_RALU; alu_o = ALU_ADD; end
          F_SUBU: begin cls_o = C_RALU; alu_o = ALU_SUB; end
          F_AND:  begin cls_o = C_RALU; alu_o = ALU_AND; end
          F_OR:   begin cls_o = C_RALU; alu_o = ALU_OR;  end
          F_SLT:  begin cls_o = C_RALU; alu_o = ALU_SLT; end
          F_SLL:  begin cls_o = C_RALU; alu_o = ALU_SLL; end
          F_SRL:  begin cls_o = C_RALU; alu_o = ALU_SRL; end
          F_JR:   cls_o = C_JR;
          default: cls_o = C_ILL;
        endcase
      end
      OP_ADDIU: begin
        cls_o     = C_IALU;
        alu_src_o = AS_SEXT;
      end
      OP_ORI: begin
        cls_o     = C_IALU;
        alu_o     = ALU_OR;
        alu_src_o = AS_ZEXT;
      end
      OP_LUI: begin
        cls_o     = C_IALU;
        alu_o     = ALU_LUI;
        alu_src_o = AS_ZEXT;
      end
      OP_LW: begin
        cls_o     = C_LW;
        alu_src_o = AS_SEXT;
      end
      OP_SW: begin
        cls_o     = C_SW;
        alu_src_o = AS_SEXT;
      end
      OP_BEQ: begin
        cls_o = C_BEQ;
        alu_o = ALU_SUB;
      end
      OP_BNE: begin
        cls_o = C_BNE;
        alu_o = ALU_SUB;
      end
      OP_J:   cls_o = C_J;
      OP_JAL: cls_o = C_JAL;
      default: cls_o = C_ILL;
    endcase
  end

  assign illegal_o = (cls_o == C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a
// shared datapath and one unified memory port with req/ready.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int LINK_REG = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               ir_we,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic [1:0]         alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [2:0]         state
);

  if (LINK_REG < 1 || LINK_REG > 31) begin : g_link_chk
    $error("LINK_REG must name a register 1..31");
  end

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d;
  alu_t       alu_q, alu_d;
  logic [1:0] asrc_q, asrc_d;
  logic       ill_q, ill_d;

  cls_t       dec_cls;
  alu_t       dec_alu;
  logic [1:0] dec_src;
  logic       dec_ill;
  alu_t       alu_sel;

  ctrl_decode u_dec (
    .op_i      (op),
    .func_i    (func),
    .cls_o     (dec_cls),
    .alu_o     (dec_alu),
    .alu_src_o (dec_src),
    .illegal_o (dec_ill)
  );

  // State and latched decode, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      cls_q   <= C_NONE;
      alu_q   <= ALU_ADD;
      asrc_q  <= AS_RT;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      asrc_q  <= asrc_d;
      ill_q   <= ill_d;
    end
  end

  // Next state; decode is captured once in ID and held after
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    asrc_d  = asrc_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IF: begin
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        cls_d  = dec_cls;
        alu_d  = dec_alu;
        asrc_d = dec_src;
        if (dec_ill) begin
          state_d = S_ERR;
          ill_d   = 1'b1;
        end else if (dec_cls == C_J || dec_cls == C_JAL) begin
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        unique case (cls_q)
          C_BEQ, C_BNE, C_JR: state_d = S_IF;
          C_LW, C_SW:         state_d = S_MEM;
          default:            state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls_q == C_LW) ? S_WB : S_IF;
        end
      end
      S_WB:  state_d = S_IF;
      S_ERR: state_d = S_ERR;
      default: state_d = S_IF;
    endcase
  end

  // Datapath controls; everything forced idle while rst is high
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    iord    = 1'b0;
    pc_we   = 1'b0;
    pc_src  = PC_PLUS4;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    reg_dst = RD_RT;
    wb_sel  = WB_ALU;
    alu_src = AS_RT;
    alu_sel = ALU_ADD;
    if (!rst) begin
      unique case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_ID: begin
          if (dec_cls == C_J || dec_cls == C_JAL) begin
            pc_we  = 1'b1;
            pc_src = PC_JUMP;
          end
          if (dec_cls == C_JAL) begin
            reg_we  = 1'b1;
            reg_dst = RD_LINK;
            wb_sel  = WB_PC;
          end
        end
        S_EX: begin
          alu_sel = alu_q;
          alu_src = asrc_q;
          unique case (cls_q)
            C_BEQ: begin
              pc_we  = zero;
              pc_src = PC_BRANCH;
            end
            C_BNE: begin
              pc_we  = !zero;
              pc_src = PC_BRANCH;
            end
            C_JR: begin
              pc_we  = 1'b1;
              pc_src = PC_RS;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (cls_q == C_SW);
          alu_sel = alu_q;
          alu_src = asrc_q;
        end
        S_WB: begin
          reg_we  = 1'b1;
          reg_dst = (cls_q == C_RALU) ? RD_RD : RD_RT;
          wb_sel  = (cls_q == C_LW) ? WB_MEM : WB_ALU;
          alu_sel = alu_q;
          alu_src = asrc_q;
        end
        default: ;
      endcase
    end
  end

  assign alu_op  = ALUOP_W'(alu_sel);
  assign illegal = ill_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a phase-level model builds
// the expected per-cycle control trace, compared every cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, iord, pc_we, ir_we, reg_we, illegal;
  logic [1:0] pc_src, reg_dst, wb_sel, alu_src;
  logic [3:0] alu_op;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALUOP_W(4), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal),
    .state(state)
  );

  typedef struct {
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] func;
    logic       mem_req, mem_we, iord, pc_we;
    logic [1:0] pc_src;
    logic       ir_we, reg_we;
    logic [1:0] reg_dst, wb_sel, alu_src;
    logic [3:0] alu_op;
    logic       illegal;
    logic [2:0] state;
  } rec_t;

  localparam int K_R = 0, K_JR = 1, K_I = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_BAD = 9;

  rec_t q[$];
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [21:0] act,
                     input logic [21:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  function automatic logic [21:0] pk(input rec_t r);
    return {r.mem_req, r.mem_we, r.iord, r.pc_we, r.pc_src, r.ir_we,
            r.reg_we, r.reg_dst, r.wb_sel, r.alu_src, r.alu_op,
            r.illegal, r.state};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {mem_req, mem_we, iord, pc_we, pc_src, ir_we, reg_we,
            reg_dst, wb_sel, alu_src, alu_op, illegal, state};
  endfunction

  // Instruction table: kind, ALU code, ALU B select
  task automatic classify(input logic [5:0] o, input logic [5:0] f,
                          output int k, output logic [3:0] a,
                          output logic [1:0] s);
    k = K_BAD; a = 4'd0; s = 2'd0;
    case (o)
      6'h00: case (f)
        6'h21: begin k = K_R; a = 4'd0; end
        6'h23: begin k = K_R; a = 4'd1; end
        6'h24: begin k = K_R; a = 4'd2; end
        6'h25: begin k = K_R; a = 4'd3; end
        6'h2A: begin k = K_R; a = 4'd4; end
        6'h00: begin k = K_R; a = 4'd5; end
        6'h02: begin k = K_R; a = 4'd6; end
        6'h08: k = K_JR;
        default: k = K_BAD;
      endcase
      6'h09: begin k = K_I; s = 2'd1; end
      6'h0D: begin k = K_I; a = 4'd3; s = 2'd2; end
      6'h0F: begin k = K_I; a = 4'd7; s = 2'd2; end
      6'h23: begin k = K_LW; s = 2'd1; end
      6'h2B: begin k = K_SW; s = 2'd1; end
      6'h04: begin k = K_BEQ; a = 4'd1; end
      6'h05: begin k = K_BNE; a = 4'd1; end
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      default: k = K_BAD;
    endcase
  endtask

  function automatic rec_t base(input logic [5:0] o, input logic [5:0] f,
                                input logic z, input logic [2:0] st);
    rec_t r;
    r = '{default: '0};
    r.op = o; r.func = f; r.z = z; r.state = st; r.rdy = 1'b1;
    return r;
  endfunction

  // Append the expected cycle trace of one instruction
  task automatic add_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int ifw, input int memw);
    rec_t r;
    int k;
    logic [3:0] a;
    logic [1:0] s;
    classify(o, f, k, a, s);
    for (int i = 0; i <= ifw; i++) begin
      r = base(o, f, z, 3'd0);
      r.mem_req = 1'b1;
      r.rdy = (i == ifw);
      r.ir_we = r.rdy;
      r.pc_we = r.rdy;
      q.push_back(r);
    end
    r = base(o, f, z, 3'd1);
    if (k == K_J || k == K_JAL) begin
      r.pc_we = 1'b1; r.pc_src = 2'd2;
      if (k == K_JAL) begin
        r.reg_we = 1'b1; r.reg_dst = 2'd2; r.wb_sel = 2'd2;
      end
      q.push_back(r);
      return;
    end
    q.push_back(r);
    if (k == K_BAD) begin
      for (int i = 0; i < 10; i++) begin
        r = base(o, f, z, 3'd5);
        r.illegal = 1'b1;
        r.rdy = i[0];
        q.push_back(r);
      end
      return;
    end
    r = base(o, f, z, 3'd2);
    r.alu_op = a; r.alu_src = s;
    if (k == K_BEQ) begin r.pc_we = z;  r.pc_src = 2'd1; end
    if (k == K_BNE) begin r.pc_we = !z; r.pc_src = 2'd1; end
    if (k == K_JR)  begin r.pc_we = 1'b1; r.pc_src = 2'd3; end
    q.push_back(r);
    if (k == K_BEQ || k == K_BNE || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= memw; i++) begin
        r = base(o, f, z, 3'd3);
        r.mem_req = 1'b1; r.iord = 1'b1; r.mem_we = (k == K_SW);
        r.alu_op = a; r.alu_src = s;
        r.rdy = (i == memw);
        q.push_back(r);
      end
      if (k == K_SW) return;
    end
    r = base(o, f, z, 3'd4);
    r.reg_we = 1'b1;
    r.reg_dst = (k == K_R) ? 2'd1 : 2'd0;
    r.wb_sel = (k == K_LW) ? 2'd1 : 2'd0;
    r.alu_op = a; r.alu_src = s;
    q.push_back(r);
  endtask

  // Drive each expected cycle and compare the outputs mid-cycle
  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      rst = 1'b0;
      mem_ready = r.rdy; zero = r.z; op = r.op; func = r.func;
      #1;
      chk($sformatf("cyc%0d op%h st%0d", cyc, r.op, r.state),
          dut_vec(), pk(r));
      cyc++;
    end
  endtask

  task automatic lat(input string nm, input logic [5:0] o,
                     input logic [5:0] f, input logic z, input int memw,
                     input int want);
    int n0;
    n0 = q.size();
    add_instr(o, f, z, 0, memw);
    chk({"latency ", nm}, 22'(q.size() - n0), 22'(want));
    run_q();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; op = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    #1;
    chk("reset idle", dut_vec(), 22'h0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("reset ready ignored", dut_vec(), 22'h0);

    lat("addu", 6'h00, 6'h21, 1'b0, 0, 4);
    lat("lw wait2", 6'h23, 6'h00, 1'b0, 2, 7);
    lat("beq taken", 6'h04, 6'h00, 1'b1, 0, 3);
    lat("beq not", 6'h04, 6'h00, 1'b0, 0, 3);
    lat("jal", 6'h03, 6'h00, 1'b0, 0, 2);
    lat("j", 6'h02, 6'h00, 1'b0, 0, 2);
    lat("sw", 6'h2B, 6'h00, 1'b0, 0, 4);
    lat("lw", 6'h23, 6'h00, 1'b0, 0, 5);
    lat("jr", 6'h00, 6'h08, 1'b0, 0, 3);

    add_instr(6'h05, 6'h00, 1'b0, 0, 0);
    add_instr(6'h05, 6'h00, 1'b1, 1, 0);
    add_instr(6'h00, 6'h23, 1'b0, 2, 0);
    add_instr(6'h00, 6'h24, 1'b1, 0, 0);
    add_instr(6'h00, 6'h25, 1'b0, 0, 0);
    add_instr(6'h00, 6'h2A, 1'b0, 0, 0);
    add_instr(6'h00, 6'h00, 1'b0, 0, 0);
    add_instr(6'h00, 6'h02, 1'b0, 0, 0);
    add_instr(6'h09, 6'h3F, 1'b0, 0, 0);
    add_instr(6'h0D, 6'h00, 1'b0, 0, 0);
    add_instr(6'h0F, 6'h00, 1'b0, 0, 0);
    add_instr(6'h2B, 6'h11, 1'b0, 1, 3);
    run_q();

    add_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    run_q();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("err cleared by rst", dut_vec(), 22'h0);

    add_instr(6'h00, 6'h3F, 1'b0, 0, 0);
    run_q();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("bad func cleared", dut_vec(), 22'h0);

    add_instr(6'h2B, 6'h00, 1'b0, 0, 2);
    void'(q.pop_back());
    run_q();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    chk("sw stall rst drop", dut_vec(), 22'h0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("sw rst held ready", dut_vec(), 22'h0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk("refetch after rst", dut_vec(), {3'b100, 19'h0});

    add_instr(6'h00, 6'h21, 1'b0, 1, 0);
    run_q();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
